// File: rtl/alu_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu_pkg : opcode encodings and flag bit positions shared by the ALU pipeline
// Rev 1.0
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam int ALU_OP_W  = 4;
  localparam int NUM_FLAGS = 4;

  localparam logic [ALU_OP_W-1:0] ALU_PASS = 4'd0;
  localparam logic [ALU_OP_W-1:0] ALU_NOT  = 4'd1;
  localparam logic [ALU_OP_W-1:0] ALU_ADD  = 4'd2;
  localparam logic [ALU_OP_W-1:0] ALU_NOR  = 4'd3;
  localparam logic [ALU_OP_W-1:0] ALU_SUB  = 4'd4;
  localparam logic [ALU_OP_W-1:0] ALU_NAND = 4'd5;
  localparam logic [ALU_OP_W-1:0] ALU_AND  = 4'd6;
  localparam logic [ALU_OP_W-1:0] ALU_SLT  = 4'd7;
  localparam logic [ALU_OP_W-1:0] ALU_OR   = 4'd8;
  localparam logic [ALU_OP_W-1:0] ALU_XOR  = 4'd9;
  localparam logic [ALU_OP_W-1:0] ALU_SLTU = 4'd10;
  localparam logic [ALU_OP_W-1:0] ALU_SLL  = 4'd11;
  localparam logic [ALU_OP_W-1:0] ALU_SRL  = 4'd12;
  localparam logic [ALU_OP_W-1:0] ALU_SRA  = 4'd13;

  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 2;
  localparam int FLAG_N = 3;

endpackage
`default_nettype wire

// File: rtl/alu_core.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu_core : combinational ALU, (op, a, b) -> (result, Z/C/V/N flags)
// Rev 1.0
// ---------------------------------------------------------------------------
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [ALU_OP_W-1:0]  op,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [WIDTH-1:0]     result,
  output logic [NUM_FLAGS-1:0] flags
);

  localparam int SHAMT_W = $clog2(WIDTH);

  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     sub_sum;
  logic [SHAMT_W-1:0] shamt;
  logic               carry;
  logic               ovf;

  always_comb begin
    add_sum = {1'b0, a} + {1'b0, b};
    sub_sum = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
    shamt   = b[SHAMT_W-1:0];
    result  = '0;
    carry   = 1'b0;
    ovf     = 1'b0;
    case (op)
      ALU_PASS: result = a;
      ALU_NOT:  result = ~a;
      ALU_ADD: begin
        result = add_sum[WIDTH-1:0];
        carry  = add_sum[WIDTH];
        ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (add_sum[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_NOR:  result = ~(a | b);
      // Carry out of a + ~b + 1 doubles as the unsigned no-borrow flag.
      ALU_SUB: begin
        result = sub_sum[WIDTH-1:0];
        carry  = sub_sum[WIDTH];
        ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (sub_sum[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_NAND: result = ~(a & b);
      ALU_AND:  result = a & b;
      ALU_SLT:  result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_OR:   result = a | b;
      ALU_XOR:  result = a ^ b;
      ALU_SLTU: result = {{(WIDTH-1){1'b0}}, (a < b)};
      ALU_SLL:  result = a << shamt;
      ALU_SRL:  result = a >> shamt;
      ALU_SRA:  result = $signed(a) >>> shamt;
      default:  result = '0;
    endcase
    flags         = '0;
    flags[FLAG_Z] = (result == '0);
    flags[FLAG_C] = carry;
    flags[FLAG_V] = ovf;
    flags[FLAG_N] = result[WIDTH-1];
  end

endmodule
`default_nettype wire

// File: rtl/alu_pipe.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu_pipe : two-stage valid/ready ALU; ALU_STICKY_OVF_EN adds a sticky overflow
// Rev 1.0
// ---------------------------------------------------------------------------
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ALU_OP_W-1:0] op,
  input  logic [WIDTH-1:0]    a,
  input  logic [WIDTH-1:0]    b,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    result,
  output logic                zero,
  output logic                carry,
  output logic                overflow,
  output logic                negative
`ifdef ALU_STICKY_OVF_EN
  ,
  input  logic                clr_sticky,
  output logic                sticky_ovf
`endif
);

  logic                 s1_valid_q, s1_valid_d;
  logic [ALU_OP_W-1:0]  op_q, op_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic                 s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic [NUM_FLAGS-1:0] flags_q, flags_d;
  logic [WIDTH-1:0]     core_result;
  logic [NUM_FLAGS-1:0] core_flags;
  logic                 s1_adv;
  logic                 s2_adv;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .op     (op_q),
    .a      (a_q),
    .b      (b_q),
    .result (core_result),
    .flags  (core_flags)
  );

  // Ready ripples back combinationally so a full pipe still accepts when draining.
  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv;

  always_comb begin
    s1_valid_d = s1_valid_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    s2_valid_d = s2_valid_q;
    result_d   = result_q;
    flags_d    = flags_q;
    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        op_d = op;
        a_d  = a;
        b_d  = b;
      end
    end
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        result_d = core_result;
        flags_d  = core_flags;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      s2_valid_q <= 1'b0;
      result_q   <= '0;
      flags_q    <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      s2_valid_q <= s2_valid_d;
      result_q   <= result_d;
      flags_q    <= flags_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign result    = result_q;
  assign zero      = flags_q[FLAG_Z];
  assign carry     = flags_q[FLAG_C];
  assign overflow  = flags_q[FLAG_V];
  assign negative  = flags_q[FLAG_N];

`ifdef ALU_STICKY_OVF_EN
  logic sticky_q, sticky_d;

  // Set has priority so an overflow leaving in the clearing cycle is not lost.
  always_comb begin
    sticky_d = sticky_q;
    if (clr_sticky)
      sticky_d = 1'b0;
    if (s2_valid_q && out_ready && flags_q[FLAG_V])
      sticky_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      sticky_q <= 1'b0;
    else
      sticky_q <= sticky_d;
  end

  assign sticky_ovf = sticky_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_pipe.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_alu_pipe : directed bench with an expected-result queue for alu_pipe
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_alu_pipe;

  typedef struct packed {
    logic [31:0] r;
    logic [3:0]  f;  // {zero, carry, overflow, negative}
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op;
  logic [31:0] a, b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero, carry, overflow, negative;
`ifdef ALU_STICKY_OVF_EN
  logic        clr_sticky;
  logic        sticky_ovf;
`endif

  int   n_checks = 0;
  int   n_err    = 0;
  exp_t sb_q[$];
  exp_t got;

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op         (op),
    .a          (a),
    .b          (b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .zero       (zero),
    .carry      (carry),
    .overflow   (overflow),
    .negative   (negative)
`ifdef ALU_STICKY_OVF_EN
    ,
    .clr_sticky (clr_sticky),
    .sticky_ovf (sticky_ovf)
`endif
  );

  function automatic exp_t model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    exp_t        e;
    longint      sx, sy, wide;
    logic [32:0] u;
    logic [4:0]  sh;
    logic        c, v;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    sh = y[4:0];
    e.r = '0;
    c = 1'b0;
    v = 1'b0;
    case (o)
      4'd0:  e.r = x;
      4'd1:  e.r = ~x;
      4'd2: begin
        u = {1'b0, x} + {1'b0, y};
        e.r = u[31:0];
        c = u[32];
        wide = sx + sy;
        v = (wide != longint'($signed(wide[31:0])));
      end
      4'd3:  e.r = ~(x | y);
      4'd4: begin
        e.r = x - y;
        c = (x >= y);
        wide = sx - sy;
        v = (wide != longint'($signed(wide[31:0])));
      end
      4'd5:  e.r = ~(x & y);
      4'd6:  e.r = x & y;
      4'd7:  e.r = (sx < sy) ? 32'd1 : 32'd0;
      4'd8:  e.r = x | y;
      4'd9:  e.r = x ^ y;
      4'd10: e.r = (x < y) ? 32'd1 : 32'd0;
      4'd11: e.r = x << sh;
      4'd12: e.r = x >> sh;
      4'd13: begin
        wide = sx >>> sh;
        e.r = wide[31:0];
      end
      default: e.r = '0;
    endcase
    e.f = {(e.r == 32'd0), c, v, e.r[31]};
    return e;
  endfunction

  // Scoreboard: every transfer out of the DUT is compared with the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      n_checks++;
      assert (sb_q.size() != 0) else begin
        n_err++;
        $error("FAIL unexpected_output: observed result %h, expected no output", result);
      end
      if (sb_q.size() != 0) begin
        got = sb_q.pop_front();
        n_checks++;
        assert (result === got.r) else begin
          n_err++;
          $error("FAIL result: observed %h expected %h", result, got.r);
        end
        n_checks++;
        assert ({zero, carry, overflow, negative} === got.f) else begin
          n_err++;
          $error("FAIL flags(zcvn): observed %b expected %b", {zero, carry, overflow, negative}, got.f);
        end
      end
    end
  end

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called just after a posedge; returns just after the posedge that follows the accept.
  task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    int t = 0;
    op = o;
    a = x;
    b = y;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && t < 50) begin
      t++;
      @(negedge clk);
    end
    check1("accept", in_ready, 1'b1);
    if (in_ready) sb_q.push_back(model(o, x, y));
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t = 0;
    while (sb_q.size() != 0 && t < 40) begin
      @(posedge clk);
      #1 t++;
    end
    check32("drain_pending", sb_q.size(), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    op = '0;
    a = '0;
    b = '0;
    out_ready = 1'b1;
`ifdef ALU_STICKY_OVF_EN
    clr_sticky = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check1("rst_out_valid", out_valid, 1'b0);
    check1("rst_in_ready", in_ready, 1'b1);
    check32("rst_result", result, 32'd0);
    check32("rst_flags", {28'd0, zero, carry, overflow, negative}, 32'd0);
    @(posedge clk);
    #1;

    // Overflowing ADD and its latency
    issue(4'd2, 32'h7FFF_FFFF, 32'h1);
    @(negedge clk);
    check1("latency_cycle1", out_valid, 1'b0);
    @(negedge clk);
    check1("latency_cycle2", out_valid, 1'b1);
    check32("add_ovf_result", result, 32'h8000_0000);
    check1("add_ovf_v", overflow, 1'b1);
    check1("add_ovf_c", carry, 1'b0);
    check1("add_ovf_n", negative, 1'b1);
    @(posedge clk);
    #1;
    wait_drain();

    // Back-to-back directed ops at full throughput
    issue(4'd4, 32'd5, 32'd7);
    issue(4'd4, 32'h8000_0000, 32'd1);
    issue(4'd7, 32'hFFFF_FFFF, 32'd1);
    issue(4'd10, 32'hFFFF_FFFF, 32'd1);
    issue(4'd13, 32'h8000_0000, 32'd36);
    issue(4'd15, 32'h1234_5678, 32'h9ABC_DEF0);
    issue(4'd14, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(4'd2, 32'hFFFF_FFFF, 32'd1);
    issue(4'd4, 32'd9, 32'd9);
    issue(4'd0, 32'hDEAD_BEEF, 32'd0);
    issue(4'd1, 32'h0F0F_0F0F, 32'd0);
    issue(4'd3, 32'hF000_000F, 32'h0FF0_0000);
    issue(4'd5, 32'hFFFF_0000, 32'hFF00_FF00);
    issue(4'd6, 32'hFFFF_0000, 32'hFF00_FF00);
    issue(4'd8, 32'h1200_0034, 32'h0056_7800);
    issue(4'd9, 32'hAAAA_5555, 32'hFFFF_0000);
    issue(4'd11, 32'h8000_0001, 32'd33);
    issue(4'd12, 32'h8000_0000, 32'd31);
    issue(4'd7, 32'h8000_0000, 32'h7FFF_FFFF);
    wait_drain();

    // Backpressure: two accepts fill the pipe, the third waits
    out_ready = 1'b0;
    issue(4'd2, 32'd100, 32'd23);
    issue(4'd9, 32'hFFFF_FFFF, 32'h0000_FFFF);
    op = 4'd4;
    a = 32'd1;
    b = 32'd2;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check1("stall_in_ready", in_ready, 1'b0);
      check1("stall_out_valid", out_valid, 1'b1);
      check32("stall_result", result, 32'd123);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    check1("release_in_ready", in_ready, 1'b1);
    if (in_ready) sb_q.push_back(model(4'd4, 32'd1, 32'd2));
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_drain();

    // Reset with both stages holding work
    out_ready = 1'b0;
    issue(4'd0, 32'h1111_1111, 32'd0);
    issue(4'd0, 32'h2222_2222, 32'd0);
    rst_n = 1'b0;
    op = 4'd0;
    a = 32'h3333_3333;
    in_valid = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b1;
    in_valid = 1'b0;
    sb_q.delete();
    @(negedge clk);
    check1("mid_rst_out_valid", out_valid, 1'b0);
    check1("mid_rst_in_ready", in_ready, 1'b1);
    check32("mid_rst_result", result, 32'd0);
    check32("mid_rst_flags", {28'd0, zero, carry, overflow, negative}, 32'd0);
    @(posedge clk);
    #1 out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check1("no_stale_out", out_valid, 1'b0);
    end
    @(posedge clk);
    #1;
    issue(4'd8, 32'hF0, 32'h0F);
    wait_drain();

`ifdef ALU_STICKY_OVF_EN
    clr_sticky = 1'b1;
    @(posedge clk);
    #1 clr_sticky = 1'b0;
    @(negedge clk);
    check1("sticky_cleared0", sticky_ovf, 1'b0);
    @(posedge clk);
    #1;
    issue(4'd2, 32'h7FFF_FFFF, 32'd1);
    wait_drain();
    @(negedge clk);
    check1("sticky_set", sticky_ovf, 1'b1);
    @(posedge clk);
    #1;
    issue(4'd2, 32'd1, 32'd2);
    issue(4'd0, 32'd5, 32'd0);
    wait_drain();
    @(negedge clk);
    check1("sticky_persist", sticky_ovf, 1'b1);
    @(posedge clk);
    #1 clr_sticky = 1'b1;
    @(posedge clk);
    #1 clr_sticky = 1'b0;
    @(negedge clk);
    check1("sticky_clear", sticky_ovf, 1'b0);
    @(posedge clk);
    #1 out_ready = 1'b0;
    issue(4'd4, 32'h8000_0000, 32'd1);
    begin
      int t = 0;
      while (!out_valid && t < 10) begin
        t++;
        @(negedge clk);
      end
    end
    @(posedge clk);
    #1 clr_sticky = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1 clr_sticky = 1'b0;
    @(negedge clk);
    check1("sticky_set_wins", sticky_ovf, 1'b1);
    @(posedge clk);
    #1;
    wait_drain();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire
